// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART core: parity modes, TX/RX FSM states
// and a frame-length helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Serial bit times per frame: start + data + optional parity + stop
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned parity,
                                               input int unsigned stop_bits);
        return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM with start-glitch
// rejection, parity and framing error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_done,
    output logic       o_parity_err,
    output logic       o_frame_err
);

    localparam logic [15:0] BAUD_MAX  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_MAX  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
    localparam parity_e     PAR_MODE  = parity_e'(2'(PARITY));

    logic        r_sync1, r_sync2, r_sync_d;
    rx_state_e   r_state, w_state_nxt;
    logic [15:0] r_baud, w_baud_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_par, w_par_nxt;
    logic [7:0]  r_data, w_data_nxt;
    logic        r_done, w_done_nxt;
    logic        r_perr, w_perr_nxt;
    logic        r_ferr, w_ferr_nxt;
    logic        w_fall, w_baud_last, w_par_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= i_rx;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    // A held-low line after a break never shows a 1->0 edge until it goes high again
    assign w_fall      = r_sync_d & ~r_sync2;
    assign w_baud_last = (r_baud == BAUD_MAX);
    assign w_par_exp   = (^r_shift) ^ (PAR_MODE == PAR_ODD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            r_perr  <= w_perr_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_perr_nxt  = r_perr;
        w_ferr_nxt  = r_ferr;
        case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = RX_START;
                    w_baud_nxt  = '0;
                end
            end
            RX_START: begin
                if (r_baud == HALF_MAX) begin
                    w_baud_nxt = '0;
                    if (!r_sync2) begin
                        w_state_nxt = RX_DATA;
                        w_bit_nxt   = '0;
                        w_shift_nxt = '0;
                    end else begin
                        w_state_nxt = RX_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            RX_DATA: begin
                if (w_baud_last) begin
                    w_baud_nxt         = '0;
                    w_shift_nxt[r_bit] = r_sync2;
                    if (r_bit == LAST_DATA) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = (PAR_MODE != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            RX_PARITY: begin
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_par_nxt   = r_sync2;
                    w_state_nxt = RX_STOP;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            RX_STOP: begin
                // Rearm at mid-stop so a fast sender's next start edge is not missed
                if (w_baud_last) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = RX_IDLE;
                    w_data_nxt  = r_shift;
                    w_done_nxt  = 1'b1;
                    w_perr_nxt  = (PAR_MODE != PAR_NONE) && (r_par != w_par_exp);
                    w_ferr_nxt  = ~r_sync2;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    assign o_data       = r_data;
    assign o_done       = r_done;
    assign o_parity_err = r_perr;
    assign o_frame_err  = r_ferr;

endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: inline TX serialiser plus uart_rx.
// Define UART_LOOPBACK_EN to feed the internal tx into the receiver (rx pin ignored).
module uart_core_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_parity_err,
    output logic       rx_frame_err
);

    localparam logic [15:0] BAUD_MAX  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [7:0]  DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);
    localparam parity_e     PAR_MODE  = parity_e'(2'(PARITY));

    tx_state_e   r_tx_state, w_tx_state_nxt;
    logic [15:0] r_tx_baud, w_tx_baud_nxt;
    logic [2:0]  r_tx_bit, w_tx_bit_nxt;
    logic [7:0]  r_tx_shift, w_tx_shift_nxt;
    logic        r_tx_par, w_tx_par_nxt;
    logic        w_tx_baud_last, w_tx_par_calc, w_tx, w_rx_in;

    assign w_tx_baud_last = (r_tx_baud == BAUD_MAX);
    assign w_tx_par_calc  = (^(tx_data & DATA_MASK)) ^ (PAR_MODE == PAR_ODD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_baud  <= w_tx_baud_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_par   <= w_tx_par_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_baud_nxt  = r_tx_baud;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        case (r_tx_state)
            TX_IDLE: begin
                if (tx_start) begin
                    w_tx_state_nxt = TX_START;
                    w_tx_baud_nxt  = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_shift_nxt = tx_data & DATA_MASK;
                    w_tx_par_nxt   = w_tx_par_calc;
                end
            end
            TX_START: begin
                if (w_tx_baud_last) begin
                    w_tx_baud_nxt  = '0;
                    w_tx_state_nxt = TX_DATA;
                end else begin
                    w_tx_baud_nxt = r_tx_baud + 16'd1;
                end
            end
            TX_DATA: begin
                if (w_tx_baud_last) begin
                    w_tx_baud_nxt  = '0;
                    w_tx_shift_nxt = r_tx_shift >> 1;
                    if (r_tx_bit == LAST_DATA) begin
                        w_tx_bit_nxt   = '0;
                        w_tx_state_nxt = (PAR_MODE != PAR_NONE) ? TX_PARITY : TX_STOP;
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 3'd1;
                    end
                end else begin
                    w_tx_baud_nxt = r_tx_baud + 16'd1;
                end
            end
            TX_PARITY: begin
                if (w_tx_baud_last) begin
                    w_tx_baud_nxt  = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = TX_STOP;
                end else begin
                    w_tx_baud_nxt = r_tx_baud + 16'd1;
                end
            end
            TX_STOP: begin
                if (w_tx_baud_last) begin
                    w_tx_baud_nxt = '0;
                    if (r_tx_bit == LAST_STOP) begin
                        w_tx_bit_nxt   = '0;
                        w_tx_state_nxt = TX_IDLE;
                    end else begin
                        w_tx_bit_nxt = r_tx_bit + 3'd1;
                    end
                end else begin
                    w_tx_baud_nxt = r_tx_baud + 16'd1;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    // Line level decoded from state so reset forces the idle-high level at once
    always_comb begin
        case (r_tx_state)
            TX_START:  w_tx = 1'b0;
            TX_DATA:   w_tx = r_tx_shift[0];
            TX_PARITY: w_tx = r_tx_par;
            default:   w_tx = 1'b1;
        endcase
    end

    assign tx      = w_tx;
    assign tx_busy = (r_tx_state != TX_IDLE);

`ifdef UART_LOOPBACK_EN
    logic w_rx_unused;
    assign w_rx_unused = rx;
    assign w_rx_in     = w_tx;
`else
    assign w_rx_in = rx;
`endif

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS),
        .PARITY       (PARITY)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx         (w_rx_in),
        .o_data       (rx_data),
        .o_done       (rx_done),
        .o_parity_err (rx_parity_err),
        .o_frame_err  (rx_frame_err)
    );

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: three instances (8N1 with external loopback, 7E1, 8N2),
// a frame-level model of the tx line and a queue of expected received frames.
`timescale 1ns/1ps
module tb_uart_core_param;

    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       st_a, st_b, st_c;
    logic [7:0] d_a, d_b, d_c;
    logic       tx_a, tx_b, tx_c, busy_a, busy_b, busy_c;
    logic       rx_a, rx_drv_a, rx_sel_a, rx_drv_b;
    logic [7:0] rd_a, rd_b, rd_c;
    logic       dn_a, dn_b, dn_c, pe_a, pe_b, pe_c, fe_a, fe_b, fe_c;

    assign rx_a = rx_sel_a ? tx_a : rx_drv_a;

    uart_core_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .tx_start(st_a), .tx_data(d_a), .tx(tx_a), .tx_busy(busy_a),
        .rx(rx_a), .rx_data(rd_a), .rx_done(dn_a), .rx_parity_err(pe_a), .rx_frame_err(fe_a));

    uart_core_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .tx_start(st_b), .tx_data(d_b), .tx(tx_b), .tx_busy(busy_b),
        .rx(rx_drv_b), .rx_data(rd_b), .rx_done(dn_b), .rx_parity_err(pe_b), .rx_frame_err(fe_b));

    uart_core_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .tx_start(st_c), .tx_data(d_c), .tx(tx_c), .tx_busy(busy_c),
        .rx(1'b1), .rx_data(rd_c), .rx_done(dn_c), .rx_parity_err(pe_c), .rx_frame_err(fe_c));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bit         f_active [3];
    int         f_start  [3];
    logic [7:0] f_data   [3];
    bit         exp_busy_prev [3];
    logic [9:0] q_a[$], q_b[$], q_c[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int cfg_db(input int i);  return (i == 1) ? 7 : 8; endfunction
    function automatic int cfg_par(input int i); return (i == 1) ? 2 : 0; endfunction
    function automatic int cfg_sb(input int i);  return (i == 2) ? 2 : 1; endfunction
    function automatic int frame_len(input int i);
        return 1 + cfg_db(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_sb(i);
    endfunction

    // Level of serial bit k of the frame carrying d on instance i
    function automatic logic frame_bit(input int i, input logic [7:0] d, input int k);
        logic p;
        p = 1'b0;
        for (int b = 0; b < cfg_db(i); b++) p = p ^ d[b];
        if (cfg_par(i) == 1) p = ~p;
        if (k == 0) return 1'b0;
        if (k <= cfg_db(i)) return d[k-1];
        if (cfg_par(i) != 0 && k == cfg_db(i) + 1) return p;
        return 1'b1;
    endfunction

    function automatic logic tx_of(input int i);
        case (i) 0: return tx_a; 1: return tx_b; default: return tx_c; endcase
    endfunction
    function automatic logic busy_of(input int i);
        case (i) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
    endfunction
    function automatic int qsize(input int i);
        case (i) 0: return q_a.size(); 1: return q_b.size(); default: return q_c.size(); endcase
    endfunction

    task automatic rx_check(input int i, input logic [7:0] rd, input logic pe, input logic fe);
        logic [9:0] e;
        if (qsize(i) == 0) begin
            check($sformatf("rx_done_unexpected[%0d]", i), 32'd1, 32'd0);
        end else begin
            case (i)
                0: e = q_a.pop_front();
                1: e = q_b.pop_front();
                default: e = q_c.pop_front();
            endcase
            check($sformatf("rx_data[%0d]", i), rd, e[9:2]);
            check($sformatf("rx_parity_err[%0d]", i), pe, e[1]);
            check($sformatf("rx_frame_err[%0d]", i), fe, e[0]);
        end
    endtask

    // Model: a request is taken at a clock edge where the line was not busy in the prior cycle
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) f_active[i] <= 1'b0;
        end else begin
            if (st_a && !exp_busy_prev[0]) begin f_active[0] <= 1'b1; f_start[0] <= cyc + 1; f_data[0] <= d_a; end
            if (st_b && !exp_busy_prev[1]) begin f_active[1] <= 1'b1; f_start[1] <= cyc + 1; f_data[1] <= d_b; end
            if (st_c && !exp_busy_prev[2]) begin f_active[2] <= 1'b1; f_start[2] <= cyc + 1; f_data[2] <= d_c; end
        end
    end

    always @(negedge clk) begin : cmp
        logic eb, et;
        int   off;
        cyc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            off = cyc - f_start[i];
            if (f_active[i] && off >= 0 && off < frame_len(i) * CPB) begin
                eb = 1'b1;
                et = frame_bit(i, f_data[i], off / CPB);
            end else begin
                eb = 1'b0;
                et = 1'b1;
            end
            check($sformatf("tx[%0d]@%0d", i, cyc), tx_of(i), et);
            check($sformatf("tx_busy[%0d]@%0d", i, cyc), busy_of(i), eb);
            exp_busy_prev[i] = eb;
        end
        if (dn_a) rx_check(0, rd_a, pe_a, fe_a);
        if (dn_b) rx_check(1, rd_b, pe_b, fe_b);
        if (dn_c) rx_check(2, rd_c, pe_c, fe_c);
    end

    task automatic pulse(input int i, input logic [7:0] d);
        case (i)
            0: begin st_a = 1'b1; d_a = d; end
            1: begin st_b = 1'b1; d_b = d; end
            default: begin st_c = 1'b1; d_c = d; end
        endcase
        @(negedge clk);
        st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
    endtask

    task automatic busy_len(input int i, output int n);
        n = 0;
        while (busy_of(i) && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_rx(input int i, input string nm);
        int n;
        n = 0;
        while (qsize(i) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(nm, qsize(i), 0);
    endtask

    task automatic send_serial(input int i, input logic [15:0] bits, input int nb);
        for (int k = 0; k < nb; k++) begin
            if (i == 0) rx_drv_a = bits[k];
            else        rx_drv_b = bits[k];
            repeat (CPB) @(negedge clk);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
        d_a = '0; d_b = '0; d_c = '0;
        rx_drv_a = 1'b1; rx_drv_b = 1'b1; rx_sel_a = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx_a", tx_a, 1);
        check("reset_busy_a", busy_a, 0);
        check("reset_rx_data_a", rd_a, 0);
        check("reset_rx_done_a", dn_a, 0);
        check("reset_perr_a", pe_a, 0);
        check("reset_ferr_a", fe_a, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // 8N1 0xA5 on the looped-back instance
        q_a.push_back({8'hA5, 2'b00});
        pulse(0, 8'hA5);
        busy_len(0, n);
        check("busy_len_A5", n, 40);
        wait_rx(0, "rx_done_A5");
        check("rx_data_A5", rd_a, 8'hA5);
        check("rx_perr_A5", pe_a, 0);
        check("rx_ferr_A5", fe_a, 0);
        repeat (4) @(negedge clk);

        // Reset during DATA, then a clean frame
        pulse(0, 8'hF0);
        repeat (14) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("rst_async_tx", tx_a, 1);
        check("rst_async_busy", busy_a, 0);
        repeat (2) @(negedge clk);
        check("rst_hold_tx", tx_a, 1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        q_a.push_back({8'h3C, 2'b00});
        pulse(0, 8'h3C);
        busy_len(0, n);
        check("busy_len_3C", n, 40);
        wait_rx(0, "rx_done_3C");
        check("rx_data_3C", rd_a, 8'h3C);

        // 7E1: tx parity bit, then good and flipped parity on rx
        pulse(1, 8'h53);
        repeat (34) @(negedge clk);
        check("par_bit_53", tx_b, 0);
        busy_len(1, n);
        q_b.push_back({8'h2A, 2'b00});
        send_serial(1, {6'b0, 1'b1, 1'b1, 7'h2A, 1'b0}, 10);
        wait_rx(1, "rx_done_2A");
        check("rx_perr_2A", pe_b, 0);
        q_b.push_back({8'h53, 2'b10});
        send_serial(1, {6'b0, 1'b1, 1'b1, 7'h53, 1'b0}, 10);
        wait_rx(1, "rx_done_53_badpar");
        check("rx_data_53", rd_b, 8'h53);
        check("rx_perr_53", pe_b, 1);
        check("rx_ferr_53", fe_b, 0);

        // 1-cycle glitch, then a frame whose stop bit is 0 followed by a held-low break
        rx_drv_a = 1'b1;
        rx_sel_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv_a = 1'b0;
        @(negedge clk);
        rx_drv_a = 1'b1;
        repeat (12) @(negedge clk);
        q_a.push_back({8'h96, 2'b01});
        send_serial(0, {6'b0, 1'b0, 8'h96, 1'b0}, 10);
        repeat (48) @(negedge clk);
        rx_drv_a = 1'b1;
        repeat (12) @(negedge clk);
        wait_rx(0, "rx_done_96_ferr");
        check("rx_data_96", rd_a, 8'h96);
        check("rx_ferr_96", fe_a, 1);
        check("rx_perr_96", pe_a, 0);

        // 8N2 back to back; a request mid-frame must be dropped
        pulse(2, 8'h01);
        n = 0;
        while (busy_c && n < 200) begin
            if (n == 10) begin st_c = 1'b1; d_c = 8'h55; end
            else st_c = 1'b0;
            n++;
            @(negedge clk);
        end
        st_c = 1'b0;
        check("busy_len_01", n, 44);
        pulse(2, 8'hFF);
        check("b2b_restart", busy_c, 1);
        busy_len(2, n);
        check("busy_len_FF", n, 44);

        repeat (20) @(negedge clk);
        check("q_a_drained", q_a.size(), 0);
        check("q_b_drained", q_b.size(), 0);
        check("q_c_drained", q_c.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL timeout: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Parametrised full-duplex UART core: generalised successor of the fixed 8N1 uart block.
- Configurable data width, parity, stop bits and bit period.
- Independent TX serialiser and RX deserialiser; RX has a 2-flop synchroniser, start-glitch rejection, and parity/framing error flags.
- Sits between the system bus glue and the board serial pins; one instance per serial channel.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per serial bit (100 MHz / 115200); legal range 4 to 65535.
- DATA_BITS, 8: payload bits per frame; legal range 5 to 8, sent LSB first.
- PARITY, 0: parity mode; 0 none, 1 odd, 2 even.
- STOP_BITS, 1: stop bits per frame; 1 or 2.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset, one clock domain.
- tx_start  in  1  single-cycle request; sampled only while tx_busy=0.
- tx_data  in  8  payload; bits [DATA_BITS-1:0] are used; captured on an accepted tx_start.
- tx  out  1  serial output; idles high.
- tx_busy  out  1  high from the cycle after acceptance until the end of the last stop bit.
- rx  in  1  serial input, asynchronous to clk.
- rx_data  out  8  last received payload; upper unused bits are 0.
- rx_done  out  1  one-cycle pulse when a frame completes.
- rx_parity_err  out  1  parity result of the last frame; valid with rx_done; held until the next rx_done.
- rx_frame_err  out  1  set if the first stop-bit sample is 0; same timing as rx_parity_err.

Behaviour:
- Reset (rst_n=0, async): tx=1, tx_busy=0, rx_data=0, rx_done=0, both error flags 0, both FSMs IDLE, counters 0. Reset asserted mid-frame aborts immediately; tx returns high within the same reset assertion.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_start=1 latches tx_data into the shift register. Next cycle: tx_busy=1, tx=0, state START.
  - Each state lasts exactly CLKS_PER_BIT cycles, timed by a baud counter.
  - DATA shifts out DATA_BITS bits, LSB first.
  - PARITY is present only if PARITY!=0. Even mode drives the XOR of the data bits; odd mode drives its inverse.
  - STOP drives 1 for STOP_BITS*CLKS_PER_BIT cycles, then returns to IDLE with tx_busy=0.
  - Frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
  - tx_start while busy is ignored and not queued.
  - Back-to-back frames: tx_start in the first IDLE cycle after busy falls gives zero idle gap.
- RX path: rx passes through a 2-flop synchroniser, which adds 2 cycles of latency. All sampling uses the synchronised signal.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge on the synchronised rx starts a count of CLKS_PER_BIT/2 cycles, then the start bit is sampled at mid-bit.
  - If the mid-bit start sample is 1 (glitch), return to IDLE with no rx_done.
  - After a valid start, sample each data bit, the parity bit (if enabled) and the first stop bit every CLKS_PER_BIT cycles at mid-bit.
  - On the first stop-bit sample: update rx_data, rx_parity_err and rx_frame_err, pulse rx_done for one cycle, then return to IDLE.
  - RX checks only the first stop bit, even when STOP_BITS=2. It rearms at mid-stop so it tolerates sender clock skew.
  - rx_data is updated even when an error is flagged.
  - A break condition (rx held low) gives one frame with rx_frame_err=1. RX then waits for rx to return high before it detects a new falling edge.
- TX and RX operate fully concurrently and independently.

Optional Feature:
- UART_LOOPBACK_EN
  - Defined: the RX synchroniser input is the internal tx signal and the rx pin is ignored; the tx pin still drives normally. Used for self-test.
  - Undefined: RX uses the rx pin only and no loopback mux is synthesised.

Decomposition:
- Package uart_pkg holds:
  - Parity enum: PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - FSM state typedefs for TX and RX.
  - Helper function frame_bits(DATA_BITS, PARITY, STOP_BITS).
- One natural sub-module, uart_rx, containing the synchroniser, RX FSM and error logic. TX stays inline in uart_core_param.

Test Plan:
- CLKS_PER_BIT=4, 8N1, tx_data=8'hA5, tx_start pulse -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; tx_busy high for exactly 40 cycles.
- UART_LOOPBACK_EN defined, same frame -> rx_done pulses once with rx_data=8'hA5 and both error flags 0.
- PARITY=2, DATA_BITS=7, tx_data=8'h53 -> parity bit 0 on tx. Inject a flipped parity bit on rx -> rx_parity_err=1 with rx_done.
- On rx, drive a low pulse of 1 cycle, then a frame with stop bit 0 -> glitch gives no rx_done; the frame gives rx_done with rx_frame_err=1.
- Assert rst_n=0 mid-DATA, then release and send 8'h3C -> tx=1 and tx_busy=0 during reset; the next frame is correct.
- STOP_BITS=2, two back-to-back tx_start pulses (8'h01 then 8'hFF) -> frames of 11 bit times each, no gap; second tx_start while busy is ignored.
